// File: rtl/picomips_pkg.sv
// Shared types and helpers for the picoMips accumulator core: opcodes, FSM states,
// instruction field widths and the saturating fractional multiply.
package picomips_pkg;

    localparam int OP_W = 4;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_LDI  = 4'd1,
        OP_LDSW = 4'd2,
        OP_ADD  = 4'd3,
        OP_ADDI = 4'd4,
        OP_SUB  = 4'd5,
        OP_MULI = 4'd6,
        OP_STR  = 4'd7,
        OP_MOV  = 4'd8,
        OP_JMP  = 4'd9,
        OP_BZ   = 4'd10,
        OP_WAIT = 4'd11,
        OP_HALT = 4'd12
    } opcode_t;

    typedef enum logic [2:0] {
        FETCH,
        EXEC,
        WAIT_HI,
        WAIT_LO,
        HALT
    } state_t;

    // Register index field is never narrower than one bit, even for a single register.
    function automatic int reg_aw(input int nregs);
        return (nregs > 2) ? $clog2(nregs) : 1;
    endfunction

    // Q1.(w-1) multiply on sign-extended operands; (-1.0)*(-1.0) is the only overflow.
    function automatic logic signed [31:0] fmul_sat(input logic signed [31:0] a,
                                                    input logic signed [31:0] b,
                                                    input int w);
        logic signed [63:0] a_w;
        logic signed [63:0] b_w;
        logic signed [63:0] prod;
        logic signed [31:0] max_v;
        logic signed [31:0] min_v;
        max_v = (32'sd1 <<< (w - 1)) - 32'sd1;
        min_v = -max_v - 32'sd1;
        a_w   = {{32{a[31]}}, a};
        b_w   = {{32{b[31]}}, b};
        prod  = a_w * b_w;
        if (a == min_v && b == min_v) begin
            return max_v;
        end
        return prod[(w - 1) +: 32];
    endfunction

endpackage

// File: rtl/picomips_alu_w.sv
// Combinational next-accumulator datapath: selects the new Acc value for the decoded opcode.
module picomips_alu_w
    import picomips_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  opcode_t                  op,
    input  logic signed [DATA_W-1:0] acc,
    input  logic signed [DATA_W-1:0] rdata,
    input  logic signed [DATA_W-1:0] imm,
    input  logic signed [DATA_W-1:0] sw,
    output logic signed [DATA_W-1:0] acc_next
);

    logic signed [31:0]       a_ext;
    logic signed [31:0]       b_ext;
    logic signed [31:0]       fmul_res;
    logic [31-DATA_W:0]       unused_hi;

    always_comb begin
        a_ext    = {{(33-DATA_W){acc[DATA_W-1]}}, acc[DATA_W-2:0]};
        b_ext    = {{(33-DATA_W){imm[DATA_W-1]}}, imm[DATA_W-2:0]};
        fmul_res = fmul_sat(a_ext, b_ext, DATA_W);
        acc_next = acc;
        case (op)
            OP_LDI:  acc_next = imm;
            OP_LDSW: acc_next = sw;
            OP_ADD:  acc_next = acc + rdata;
            OP_ADDI: acc_next = acc + imm;
            OP_SUB:  acc_next = acc - rdata;
            OP_MULI: acc_next = fmul_res[DATA_W-1:0];
            OP_MOV:  acc_next = rdata;
            default: acc_next = acc;
        endcase
    end

    // Upper product bits are sign copies once the result is in range.
    assign unused_hi = fmul_res[31:DATA_W];

endmodule

// File: rtl/picomips_core.sv
// Multi-cycle accumulator core: FETCH/EXEC sequencing, register file, PC, switch
// handshake waits and halt, fed by a one-cycle-latency synchronous program ROM.
module picomips_core
    import picomips_pkg::*;
#(
    parameter  int DATA_W  = 8,
    parameter  int NREGS   = 4,
    parameter  int PC_W    = 5,
    localparam int REG_AW  = reg_aw(NREGS),
    localparam int INSTR_W = OP_W + REG_AW + DATA_W
) (
    input  logic                     Clock,
    input  logic                     Reset,
    output logic [PC_W-1:0]          IMemAddr,
    input  logic [INSTR_W-1:0]       IMemData,
    input  logic [DATA_W-1:0]        SwIn,
    input  logic                     Handshake,
    output logic signed [DATA_W-1:0] Acc,
    output logic                     Halted
);

    localparam int RF_DEPTH = 2 ** REG_AW;

    state_t                   state_q;
    state_t                   state_d;
    logic [PC_W-1:0]          pc_q;
    logic [PC_W-1:0]          pc_d;
    logic signed [DATA_W-1:0] acc_q;
    logic signed [DATA_W-1:0] acc_d;
    logic signed [DATA_W-1:0] regs   [NREGS];
    logic signed [DATA_W-1:0] rd_pad [RF_DEPTH];

    opcode_t                  op;
    logic [REG_AW-1:0]        reg_idx;
    logic signed [DATA_W-1:0] imm;
    logic signed [DATA_W-1:0] rdata;
    logic                     acc_ld;
    logic                     reg_ld;

    assign op      = opcode_t'(IMemData[INSTR_W-1 -: OP_W]);
    assign reg_idx = IMemData[DATA_W +: REG_AW];
    assign imm     = IMemData[DATA_W-1:0];

    // Unpopulated register slots read as zero.
    for (genvar g = 0; g < RF_DEPTH; g++) begin : g_rd
        if (g < NREGS) begin : g_live
            assign rd_pad[g] = regs[g];
        end else begin : g_void
            assign rd_pad[g] = '0;
        end
    end
    assign rdata = rd_pad[reg_idx];

    picomips_alu_w #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op       (op),
        .acc      (acc_q),
        .rdata    (rdata),
        .imm      (imm),
        .sw       (SwIn),
        .acc_next (acc_d)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        acc_ld  = 1'b0;
        reg_ld  = 1'b0;
        case (state_q)
            FETCH: state_d = EXEC;
            EXEC: begin
                state_d = FETCH;
                pc_d    = pc_q + PC_W'(1);
                case (op)
                    OP_JMP: pc_d = imm[PC_W-1:0];
                    OP_BZ: begin
                        if (acc_q == '0) pc_d = imm[PC_W-1:0];
                    end
                    OP_STR: reg_ld = 1'b1;
                    OP_WAIT: begin
                        state_d = WAIT_HI;
                        pc_d    = pc_q;
                    end
                    OP_HALT: begin
                        state_d = HALT;
                        pc_d    = pc_q;
                    end
                    default: acc_ld = 1'b1;
                endcase
            end
            WAIT_HI: begin
                if (Handshake) state_d = WAIT_LO;
            end
            WAIT_LO: begin
                if (!Handshake) begin
                    state_d = FETCH;
                    pc_d    = pc_q + PC_W'(1);
                end
            end
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= FETCH;
            pc_q    <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (acc_ld) acc_q <= acc_d;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int k = 0; k < NREGS; k++) regs[k] <= '0;
        end else if (reg_ld) begin
            for (int k = 0; k < NREGS; k++) begin
                if (reg_idx == REG_AW'(k)) regs[k] <= acc_q;
            end
        end
    end

    assign IMemAddr = pc_q;
    assign Acc      = acc_q;
    assign Halted   = (state_q == HALT);

endmodule
